// File: rtl/prog_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_rom : byte-wide program store with lane-serial word fetch, streaming  |
// |            byte loader and a freezable change-detecting monitor bank.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module prog_rom #(
  parameter int ADDR_W      = 8,
  parameter int FETCH_BYTES = 4,
  parameter int MON_CH      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [ADDR_W-1:0]        fetch_addr,
  output logic                     fetch_busy,
  output logic                     fetch_valid,
  output logic [8*FETCH_BYTES-1:0] opcode,
  input  logic                     load_start,
  input  logic [ADDR_W-1:0]        load_addr,
  input  logic                     load_valid,
  input  logic [7:0]               load_data,
  output logic                     load_ready,
  input  logic [8*MON_CH-1:0]      mon_in,
  input  logic                     mon_freeze,
  input  logic                     mon_clr,
  output logic [8*MON_CH-1:0]      mon_out,
  output logic [MON_CH-1:0]        mon_changed
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LANE_W = (FETCH_BYTES > 1) ? $clog2(FETCH_BYTES) : 1;
  localparam logic [LANE_W-1:0] C_LAST_LANE = LANE_W'(FETCH_BYTES - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  state_t                   r_state;
  logic [ADDR_W-1:0]        r_base;
  logic [LANE_W-1:0]        r_lane;
  logic [8*FETCH_BYTES-1:0] r_opcode;
  logic                     r_fetch_busy;
  logic                     r_fetch_valid;
  logic [ADDR_W-1:0]        r_lptr;

  // Boot image lives in the array initializer so reset never touches it.
  logic [7:0] r_mem [DEPTH] = '{0: 8'h01, 1: 8'h02, 2: 8'h03, 3: 8'h04, default: 8'h00};

  logic              w_load_ready;
  logic              w_load_acc;
  logic [ADDR_W-1:0] w_waddr;
  logic [ADDR_W-1:0] w_raddr;
  logic [7:0]        w_rd_byte;

  // Writes happen only in IDLE and reads only in FETCH, so the port is never shared.
  assign w_load_ready = (r_state == S_IDLE) && !fetch_req;
  assign w_load_acc   = load_valid && w_load_ready;
  assign w_waddr      = load_start ? load_addr : r_lptr;
  assign w_raddr      = r_base + ADDR_W'(r_lane);
  assign w_rd_byte    = r_mem[w_raddr];

  assign load_ready  = w_load_ready;
  assign fetch_busy  = r_fetch_busy;
  assign fetch_valid = r_fetch_valid;
  assign opcode      = r_opcode;

  always_ff @(posedge clk) begin
    if (w_load_acc) begin
      r_mem[w_waddr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lptr <= '0;
    end else if (w_load_acc) begin
      r_lptr <= w_waddr + ADDR_W'(1);
    end else if (load_start) begin
      r_lptr <= load_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_base        <= '0;
      r_lane        <= '0;
      r_opcode      <= '0;
      r_fetch_busy  <= 1'b0;
      r_fetch_valid <= 1'b0;
    end else begin
      r_fetch_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (fetch_req) begin
            r_base       <= fetch_addr;
            r_lane       <= '0;
            r_state      <= S_FETCH;
            r_fetch_busy <= 1'b1;
          end
        end
        S_FETCH: begin
          r_opcode[8*r_lane +: 8] <= w_rd_byte;
          if (r_lane == C_LAST_LANE) begin
            r_state       <= S_IDLE;
            r_fetch_busy  <= 1'b0;
            r_fetch_valid <= 1'b1;
          end else begin
            r_lane <= r_lane + LANE_W'(1);
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_fetch_busy <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < MON_CH; k++) begin : g_mon
    logic [7:0] w_in;
    logic       w_set;
    logic [7:0] r_val;
    logic       r_chg;

    assign w_in  = mon_in[8*k +: 8];
    assign w_set = !mon_freeze && (w_in != r_val);

    // A fresh change outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_val <= '0;
        r_chg <= 1'b0;
      end else begin
        if (!mon_freeze) begin
          r_val <= w_in;
        end
        if (w_set) begin
          r_chg <= 1'b1;
        end else if (mon_clr) begin
          r_chg <= 1'b0;
        end
      end
    end

    assign mon_out[8*k +: 8] = r_val;
    assign mon_changed[k]    = r_chg;
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_prog_rom : randomized bench for prog_rom against a behavioural model.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_prog_rom;
  localparam int ADDR_W = 8;
  localparam int FB     = 4;
  localparam int MC     = 16;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              fetch_busy;
  logic              fetch_valid;
  logic [8*FB-1:0]   opcode;
  logic              load_start = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic              load_valid = 1'b0;
  logic [7:0]        load_data = '0;
  logic              load_ready;
  logic [8*MC-1:0]   mon_in = '0;
  logic              mon_freeze = 1'b0;
  logic              mon_clr = 1'b0;
  logic [8*MC-1:0]   mon_out;
  logic [MC-1:0]     mon_changed;

  prog_rom #(.ADDR_W(ADDR_W), .FETCH_BYTES(FB), .MON_CH(MC)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_busy(fetch_busy),
    .fetch_valid(fetch_valid), .opcode(opcode),
    .load_start(load_start), .load_addr(load_addr), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready),
    .mon_in(mon_in), .mon_freeze(mon_freeze), .mon_clr(mon_clr),
    .mon_out(mon_out), .mon_changed(mon_changed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]        m_mem [DEPTH];
  logic [ADDR_W-1:0] m_ptr;
  logic [7:0]        m_mon [MC];
  logic              m_chg [MC];

  task automatic model_reset();
    m_ptr = '0;
    for (int k = 0; k < MC; k++) begin
      m_mon[k] = '0;
      m_chg[k] = 1'b0;
    end
  endtask

  function automatic logic [8*FB-1:0] exp_word(input logic [ADDR_W-1:0] a);
    logic [8*FB-1:0] w;
    for (int k = 0; k < FB; k++) w[8*k +: 8] = m_mem[(int'(a) + k) % DEPTH];
    return w;
  endfunction

  function automatic logic [8*MC-1:0] exp_mon();
    logic [8*MC-1:0] v;
    for (int k = 0; k < MC; k++) v[8*k +: 8] = m_mon[k];
    return v;
  endfunction

  function automatic logic [MC-1:0] exp_chg();
    logic [MC-1:0] v;
    for (int k = 0; k < MC; k++) v[k] = m_chg[k];
    return v;
  endfunction

  // Advance one clock, applying the monitor rules to the inputs held this cycle.
  task automatic step();
    logic [7:0] nin;
    logic       set;
    if (rst) begin
      for (int k = 0; k < MC; k++) begin
        nin = mon_in[8*k +: 8];
        set = !mon_freeze && (nin != m_mon[k]);
        if (mon_clr) m_chg[k] = 1'b0;
        if (set) m_chg[k] = 1'b1;
        if (!mon_freeze) m_mon[k] = nin;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic st, input logic [7:0] a, input logic [7:0] d);
    load_start = st; load_addr = a; load_valid = 1'b1; load_data = d;
    if (st) m_ptr = a;
    m_mem[m_ptr] = d;
    m_ptr = m_ptr + 8'd1;
    step();
    load_start = 1'b0; load_valid = 1'b0;
  endtask

  task automatic do_fetch(input logic [7:0] a, output logic [8*FB-1:0] op, output int lat);
    fetch_req = 1'b1; fetch_addr = a;
    step();
    fetch_req = 1'b0; fetch_addr = 8'($urandom);
    lat = 1;
    while (fetch_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    op = opcode;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (fetch_busy !== 1'b0 || fetch_valid !== 1'b0 || opcode !== '0) begin
      errors++;
      $display("FAIL reset_fetch: busy=%b valid=%b opcode=%h, want 0 0 0", fetch_busy, fetch_valid, opcode);
    end
    checks++;
    if (mon_out !== '0 || mon_changed !== '0) begin
      errors++;
      $display("FAIL reset_mon: mon_out=%h changed=%h, want 0", mon_out, mon_changed);
    end
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_load_ready: got %b want 1", load_ready);
    end
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_fetch_basic();
    logic [8*FB-1:0] op;
    int lat;
    fetch_req = 1'b1; fetch_addr = 8'h00;
    step();
    fetch_req = 1'b0;
    checks++;
    if (fetch_busy !== 1'b1) begin
      errors++;
      $display("FAIL fetch_busy: got %b want 1", fetch_busy);
    end
    lat = 1;
    while (fetch_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    op = opcode;
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL fetch_latency: got %0d want 5", lat);
    end
    checks++;
    if (op !== 32'h04030201) begin
      errors++;
      $display("FAIL fetch_boot_word: got %h want 04030201", op);
    end
    step();
    checks++;
    if (fetch_valid !== 1'b0 || opcode !== 32'h04030201) begin
      errors++;
      $display("FAIL fetch_valid_pulse: valid=%b opcode=%h, want 0 04030201", fetch_valid, opcode);
    end
  endtask

  task automatic test_wrap_fetch();
    logic [8*FB-1:0] op;
    int lat;
    load_byte(1'b1, 8'hFE, 8'hAA);
    load_byte(1'b0, 8'h00, 8'hBB);
    do_fetch(8'hFE, op, lat);
    checks++;
    if (lat !== 5 || op !== 32'h0201BBAA) begin
      errors++;
      $display("FAIL wrap_fetch: lat=%0d opcode=%h, want 5 0201bbaa", lat, op);
    end
  endtask

  task automatic test_load_pointer();
    logic [8*FB-1:0] op;
    int lat;
    load_byte(1'b1, 8'hFF, 8'h11);
    load_byte(1'b0, 8'h00, 8'h22);
    load_byte(1'b0, 8'h00, 8'h33);
    do_fetch(8'hFF, op, lat);
    checks++;
    if (op !== 32'h03332211 || op !== exp_word(8'hFF)) begin
      errors++;
      $display("FAIL load_pointer_wrap: got %h want 03332211", op);
    end
  endtask

  task automatic test_contention();
    logic [8*FB-1:0] op;
    logic [8*FB-1:0] want;
    int lat;
    logic ready_seen;
    want = exp_word(8'h10);
    fetch_req = 1'b1; fetch_addr = 8'h10;
    load_valid = 1'b1; load_data = 8'h77;
    #1;
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL contention_ready: got %b want 0", load_ready);
    end
    step();
    fetch_req = 1'b0;
    lat = 1;
    ready_seen = 1'b0;
    while (fetch_valid !== 1'b1 && lat < 20) begin
      if (load_ready !== 1'b0) ready_seen = 1'b1;
      step();
      lat++;
    end
    op = opcode;
    checks++;
    if (lat !== 5 || op !== want || ready_seen) begin
      errors++;
      $display("FAIL contention_fetch: lat=%0d opcode=%h ready_in_fetch=%b, want 5 %h 0", lat, op, ready_seen, want);
    end
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL contention_ready_after: got %b want 1", load_ready);
    end
    m_mem[m_ptr] = 8'h77;
    m_ptr = m_ptr + 8'd1;
    step();
    load_valid = 1'b0;
    do_fetch(m_ptr - 8'd1, op, lat);
    checks++;
    if (op[7:0] !== 8'h77 || op !== exp_word(m_ptr - 8'd1)) begin
      errors++;
      $display("FAIL contention_write: got %h want %h", op, exp_word(m_ptr - 8'd1));
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic [8*FB-1:0] op;
    int lat;
    logic valid_seen;
    fetch_req = 1'b1; fetch_addr = 8'h00;
    step();
    fetch_req = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (opcode !== '0 || fetch_busy !== 1'b0 || fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fetch: opcode=%h busy=%b valid=%b, want 0 0 0", opcode, fetch_busy, fetch_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    valid_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (fetch_valid !== 1'b0) valid_seen = 1'b1;
      step();
    end
    checks++;
    if (valid_seen) begin
      errors++;
      $display("FAIL reset_abort: fetch_valid seen %b want 0", valid_seen);
    end
    do_fetch(8'hFE, op, lat);
    checks++;
    if (lat !== 5 || op !== exp_word(8'hFE)) begin
      errors++;
      $display("FAIL fetch_after_reset: lat=%0d opcode=%h, want 5 %h", lat, op, exp_word(8'hFE));
    end
    load_byte(1'b0, 8'h00, 8'h5C);
    do_fetch(8'h00, op, lat);
    checks++;
    if (op[7:0] !== 8'h5C || op !== exp_word(8'h00)) begin
      errors++;
      $display("FAIL pointer_reset: got %h want %h", op, exp_word(8'h00));
    end
  endtask

  task automatic test_monitor();
    mon_in = '0; mon_freeze = 1'b0; mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
    mon_in[31:24] = 8'h5A;
    step();
    checks++;
    if (mon_out[31:24] !== 8'h5A || mon_changed[3] !== 1'b1) begin
      errors++;
      $display("FAIL mon_capture: ch3=%h chg=%b, want 5a 1", mon_out[31:24], mon_changed[3]);
    end
    mon_freeze = 1'b1;
    mon_in[31:24] = 8'h11;
    repeat (3) step();
    checks++;
    if (mon_out[31:24] !== 8'h5A || mon_changed[3] !== 1'b1) begin
      errors++;
      $display("FAIL mon_freeze: ch3=%h chg=%b, want 5a 1", mon_out[31:24], mon_changed[3]);
    end
    mon_freeze = 1'b0; mon_clr = 1'b1;
    mon_in[31:24] = 8'h5A;
    step();
    checks++;
    if (mon_changed[3] !== 1'b0 || mon_out[31:24] !== 8'h5A) begin
      errors++;
      $display("FAIL mon_clear: ch3=%h chg=%b, want 5a 0", mon_out[31:24], mon_changed[3]);
    end
    mon_in[31:24] = 8'h66;
    step();
    mon_clr = 1'b0;
    checks++;
    if (mon_changed[3] !== 1'b1 || mon_out !== exp_mon() || mon_changed !== exp_chg()) begin
      errors++;
      $display("FAIL mon_set_wins: chg=%h mon=%h, want %h %h", mon_changed, mon_out, exp_chg(), exp_mon());
    end
  endtask

  task automatic test_random();
    logic [8*FB-1:0] op;
    int lat;
    for (int it = 0; it < 60; it++) begin
      for (int k = 0; k < MC; k++) begin
        if ($urandom_range(3) == 0) mon_in[8*k +: 8] = 8'($urandom);
      end
      mon_freeze = ($urandom_range(3) == 0);
      mon_clr    = ($urandom_range(4) == 0);
      if ($urandom_range(2) != 0) begin
        load_byte(1'($urandom_range(1)), 8'($urandom), 8'($urandom));
      end else begin
        do_fetch(8'($urandom), op, lat);
        checks++;
        if (lat !== 5 || op !== exp_word(dut.r_base)) begin
          errors++;
          $display("FAIL rand_fetch: lat=%0d opcode=%h want 5 %h", lat, op, exp_word(dut.r_base));
        end
      end
      checks++;
      if (mon_out !== exp_mon() || mon_changed !== exp_chg()) begin
        errors++;
        $display("FAIL rand_mon: mon=%h chg=%h want %h %h", mon_out, mon_changed, exp_mon(), exp_chg());
      end
    end
    mon_freeze = 1'b0; mon_clr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = (i < 4) ? 8'(i + 1) : 8'h00;
    model_reset();
    test_reset();
    test_fetch_basic();
    test_wrap_fetch();
    test_load_pointer();
    test_contention();
    test_reset_mid_fetch();
    test_monitor();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
